// File: rtl/aes_encrypt_iter_if.sv
// aes_encrypt_iter_if: block handshake bundle for the iterative AES encryptor.
//   in_valid/in_ready/in/key : plaintext and cipher key offer (master -> slave)
//   out_valid/out_ready/out  : ciphertext delivery (slave -> master)
//   busy                     : core is executing rounds
interface aes_encrypt_iter_if #(parameter int KEY_BITS = 128);
  logic                in_valid;
  logic                in_ready;
  logic [127:0]        in;
  logic [KEY_BITS-1:0] key;
  logic                out_valid;
  logic                out_ready;
  logic [127:0]        out;
  logic                busy;
  modport master (output in_valid, in, key, out_ready, input in_ready, out_valid, out, busy);
  modport slave (input in_valid, in, key, out_ready, output in_ready, out_valid, out, busy);
endinterface

// File: rtl/aes_encrypt_iter.sv
// aes_encrypt_iter: iterative AES-128/192/256 encryptor, one round per clock.
//   clk, rst  : clock and synchronous active-high reset
//   bus       : aes_encrypt_iter_if slave (in/key handshake, out handshake, busy)
//   round_dbg : current round counter, present only with AES_ROUND_DBG_EN defined
// Round keys are expanded on the fly from a sliding window of the last NK key words.
module aes_encrypt_iter #(parameter int KEY_BITS = 128) (
  input logic clk,
  input logic rst,
  aes_encrypt_iter_if.slave bus
`ifdef AES_ROUND_DBG_EN
  , output logic [3:0] round_dbg
`endif
);
  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;
  state_t       r_state;
  logic [127:0] r_st, r_out;
  logic [31:0]  r_w [NK];
  logic [3:0]   r_cnt;
  logic [2:0]   r_ph;
  logic [7:0]   r_rc;
  logic [31:0]  w_new [4];
  logic [31:0]  w_hi [NK];
  logic [31:0]  w_prev;
  logic         w_use_rc;
  logic [127:0] w_rk, w_sr, w_nxt;
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = xt(x);
    end
    return p;
  endfunction
  // S-box as GF(2^8) inverse (a^254) followed by the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] s, r;
    s = gm(a, a);
    r = s;
    for (int i = 0; i < 6; i++) begin
      s = gm(s, s);
      r = gm(r, s);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [31:0] sw(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
    return o;
  endfunction
  function automatic logic [127:0] mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a [4];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = s[127-32*c-8*r -: 8];
      for (int r = 0; r < 4; r++)
        o[127-32*c-8*r -: 8] = xt(a[r]) ^ xt(a[(r+1)%4]) ^ a[(r+1)%4] ^ a[(r+2)%4] ^ a[(r+3)%4];
    end
    return o;
  endfunction
  // Four new schedule words per cycle; word n+k depends on word n+k-NK (window slot k)
  always_comb begin
    w_prev = r_w[NK-1];
    w_use_rc = 1'b0;
    for (int k = 0; k < 4; k++) begin
      w_new[k] = r_w[k] ^ (((int'(r_ph) + k) % NK == 0) ? sw({w_prev[23:0], w_prev[31:24]}) ^ {r_rc, 24'h0} :
                           (NK == 8 && (int'(r_ph) + k) % NK == 4) ? sw(w_prev) : w_prev);
      w_use_rc = w_use_rc | ((int'(r_ph) + k) % NK == 0);
      w_prev = w_new[k];
    end
  end
  // Window plus new words, dropping the oldest four; slots 0..3 are this round's key
  for (genvar j = 0; j < NK; j++) begin : g_hi
    if (j + 4 < NK) begin : g_old
      assign w_hi[j] = r_w[j+4];
    end else begin : g_new
      assign w_hi[j] = w_new[j+4-NK];
    end
  end
  assign w_rk = {w_hi[0], w_hi[1], w_hi[2], w_hi[3]};
  assign w_sr = sub_shift(r_st);
  assign w_nxt = (r_cnt == 4'(NR) ? w_sr : mix(w_sr)) ^ w_rk;
  assign bus.in_ready = r_state == IDLE;
  assign bus.out_valid = r_state == DONE;
  assign bus.busy = r_state == ROUND;
  assign bus.out = r_out;
`ifdef AES_ROUND_DBG_EN
  assign round_dbg = r_cnt;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_st <= '0;
      r_out <= '0;
      r_cnt <= '0;
      r_ph <= '0;
      r_rc <= '0;
      for (int j = 0; j < NK; j++) r_w[j] <= '0;
    end else if (r_state == IDLE) begin
      if (bus.in_valid) begin
        r_state <= ROUND;
        r_st <= bus.in ^ bus.key[KEY_BITS-1 -: 128];
        r_cnt <= 4'd1;
        r_ph <= '0;
        r_rc <= 8'h01;
        for (int j = 0; j < NK; j++) r_w[j] <= bus.key[KEY_BITS-1-32*j -: 32];
      end
    end else if (r_state == ROUND) begin
      r_st <= w_nxt;
      r_ph <= 3'((int'(r_ph) + 4) % NK);
      r_rc <= w_use_rc ? xt(r_rc) : r_rc;
      for (int j = 0; j < NK; j++) r_w[j] <= w_hi[j];
      if (r_cnt == 4'(NR)) begin
        r_state <= DONE;
        r_out <= w_nxt;
      end else r_cnt <= r_cnt + 4'd1;
    end else if (bus.out_ready) begin
      r_state <= IDLE;
      r_cnt <= '0;
    end
  end
endmodule

// File: tb/tb_aes_encrypt_iter.sv
// tb_aes_encrypt_iter: scoreboard bench driving AES-128/192/256 instances in lockstep.
module tb_aes_encrypt_iter;
  typedef struct packed {logic [2:0] c; logic [2:0][127:0] e;} ent_t;
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] K = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [2:0][127:0] E = {128'h8ea2b7ca516745bfeafc49904b496089,
                                     128'hdda97ca4864cdfe06eaf70a0ec0d7191,
                                     128'h69c4e0d86a7b0430d8cdb78070b4c55a};
  localparam logic [2:0][127:0] EZ = {256'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
  localparam logic [127:0] BPT = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [255:0] BK = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [2:0][127:0] BE = {256'h0, 128'h3925841d02dc09fbdc118597196a0b32};
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic [127:0] din = '0;
  logic [255:0] key = '0;
  logic [2:0] ov, ir, bz;
  logic [2:0] pv = '0;
  logic [2:0][127:0] od, hold;
`ifdef AES_ROUND_DBG_EN
  logic [2:0][3:0] dbg;
`endif
  ent_t q[$];
  ent_t me;
  int rd[3] = '{0, 0, 0};
  int cyc = 0, acc = 0, t1 = 0, n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  for (genvar g = 0; g < 3; g++) begin : g_d
    localparam int KB = 128 + 64 * g;
    aes_encrypt_iter_if #(.KEY_BITS(KB)) b ();
    aes_encrypt_iter #(.KEY_BITS(KB)) u_dut (
      .clk(clk), .rst(rst), .bus(b)
`ifdef AES_ROUND_DBG_EN
      , .round_dbg(dbg[g])
`endif
    );
    assign b.in_valid = in_valid;
    assign b.in = din;
    assign b.key = key[255 -: KB];
    assign b.out_ready = out_ready;
    assign ov[g] = b.out_valid;
    assign ir[g] = b.in_ready;
    assign bz[g] = b.busy;
    assign od[g] = b.out;
  end
  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      for (int g = 0; g < 3; g++) begin
        if (ov[g] && !pv[g]) chk($sformatf("latency%0d", g), 128'(cyc - acc), 128'(10 + 2 * g));
        if (ov[g] && out_ready) begin
          chk($sformatf("entry%0d", g), 128'(rd[g] < q.size()), 128'd1);
          if (rd[g] < q.size()) begin
            me = q[rd[g]];
            if (me.c[g]) chk($sformatf("out%0d", g), od[g], me.e[g]);
            rd[g]++;
          end
        end
      end
    end
    pv = ov;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_ready();
    int n = 0;
    while (ir != 3'b111 && n < 100) begin
      step();
      n++;
    end
    chk("ready_wait", 128'(ir), 128'h7);
  endtask
  task automatic send(input logic [127:0] pt, input logic [255:0] k, input logic [2:0][127:0] e,
                      input logic [2:0] c, input logic push);
    wait_ready();
    din = pt;
    key = k;
    in_valid = 1'b1;
    if (push) q.push_back({c, e});
    step();
    acc = cyc;
    in_valid = 1'b0;
    chk("busy", 128'(bz), 128'h7);
  endtask
  initial begin
    int n;
    repeat (3) step();
    chk("rst_ready", 128'(ir), 128'h7);
    chk("rst_valid", 128'(ov), 128'h0);
    chk("rst_busy", 128'(bz), 128'h0);
    for (int g = 0; g < 3; g++) chk($sformatf("rst_out%0d", g), od[g], 128'h0);
    rst = 1'b0;
    send(PT, K, E, 3'b111, 1'b1);
    t1 = acc;
    send(PT, K, E, 3'b111, 1'b1);
    chk("spacing", 128'(acc - t1), 128'd16);
    send(128'h0, 256'h0, EZ, 3'b001, 1'b1);
    send(BPT, BK, BE, 3'b001, 1'b1);
    send(PT, K, E, 3'b111, 1'b1);
    in_valid = 1'b1;
    repeat (5) begin
      din = {$urandom, $urandom, $urandom, $urandom};
      key = {8{$urandom}};
      step();
    end
    in_valid = 1'b0;
    wait_ready();
    out_ready = 1'b0;
    send(PT, K, E, 3'b111, 1'b1);
    n = 0;
    while (ov != 3'b111 && n < 50) begin
      step();
      n++;
    end
    chk("bp_valid_wait", 128'(ov), 128'h7);
    hold = od;
    repeat (5) begin
      step();
      chk("bp_valid", 128'(ov), 128'h7);
      chk("bp_ready", 128'(ir), 128'h0);
      for (int g = 0; g < 3; g++) chk($sformatf("bp_out%0d", g), od[g], hold[g]);
    end
    out_ready = 1'b1;
    step();
    chk("bp_release", 128'(ir), 128'h7);
    send(PT, K, E, 3'b111, 1'b0);
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_ready", 128'(ir), 128'h7);
    chk("abort_valid", 128'(ov), 128'h0);
    chk("abort_busy", 128'(bz), 128'h0);
    for (int g = 0; g < 3; g++) chk($sformatf("abort_out%0d", g), od[g], 128'h0);
    repeat (30) step();
    for (int g = 0; g < 3; g++) chk($sformatf("drain%0d", g), 128'(rd[g]), 128'(q.size()));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end
endmodule
